// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 sequencing controller.
//   - NS phase encodings driven to the RC4 core (INIT, KEY_GENE, EN_DE_CODE, HOLD)
//   - state_e: controller FSM state type
package rc4_pkg;

  localparam logic [1:0] INIT       = 2'b00;
  localparam logic [1:0] KEY_GENE   = 2'b01;
  localparam logic [1:0] EN_DE_CODE = 2'b10;
  localparam logic [1:0] HOLD       = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StKsa,
    StCrypt,
    StFlush
  } state_e;

endpackage

// File: rtl/rc4_key_ram.sv
// rc4_key_ram: KEY_MAX_LEN x 8 key store, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
// Ports:
//   clk_i            write clock
//   we_i/waddr_i/wdata_i  write port
//   raddr_i/rdata_o  combinational read port
module rc4_key_ram #(
  parameter int unsigned KEY_MAX_LEN = 16
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [$clog2(KEY_MAX_LEN)-1:0] waddr_i,
  input  logic [7:0]                     wdata_i,
  input  logic [$clog2(KEY_MAX_LEN)-1:0] raddr_i,
  output logic [7:0]                     rdata_o
);

  logic [7:0] mem_q [KEY_MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rc4_seq_ctrl.sv
// rc4_seq_ctrl: sequences an external RC4 core through key scheduling (KSA)
// and a byte-at-a-time encrypt/decrypt stream.
// Ports:
//   clk, rst (async, active-low)
//   key_we/key_addr/key_wdata  key byte write port (ignored while busy)
//   key_len, msg_len           sampled on start
//   start, abort               command pulses (abort wins)
//   din/din_valid/din_ready    input byte stream
//   dout/dout_valid/dout_ready result stream (1-cycle latency, registered)
//   busy, done, err            status; done/err are one-cycle pulses
//   NS                         core phase; key_init key byte to core
//   data_rready                core KSA complete; num keystream byte
// Build option: define RC4_TIMEOUT_EN to abort KSA with err after
// KSA_TIMEOUT cycles without data_rready.
module rc4_seq_ctrl
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_MAX_LEN = 16,
  parameter int unsigned MSG_W       = 16,
  parameter int unsigned KSA_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_we,
  input  logic [$clog2(KEY_MAX_LEN)-1:0] key_addr,
  input  logic [7:0]                     key_wdata,
  input  logic [$clog2(KEY_MAX_LEN):0]   key_len,
  input  logic [MSG_W-1:0]               msg_len,
  input  logic                           start,
  input  logic                           abort,
  input  logic [7:0]                     din,
  input  logic                           din_valid,
  output logic                           din_ready,
  output logic [7:0]                     dout,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [1:0]                     NS,
  output logic [7:0]                     key_init,
  input  logic                           data_rready,
  input  logic [7:0]                     num
);

  localparam int unsigned AW = $clog2(KEY_MAX_LEN);

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        len_q, len_d;
  logic [MSG_W-1:0]   rem_q, rem_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         ram_rdata;
  logic               key_ok;
  logic               out_free;
  logic               accept;
  logic               ksa_expired;

  rc4_key_ram #(
    .KEY_MAX_LEN (KEY_MAX_LEN)
  ) u_key_ram (
    .clk_i   (clk),
    .we_i    (key_we && (state_q == StIdle)),
    .waddr_i (key_addr),
    .wdata_i (key_wdata),
    .raddr_i (idx_q),
    .rdata_o (ram_rdata)
  );

`ifdef RC4_TIMEOUT_EN
  localparam int unsigned TcW = $clog2(KSA_TIMEOUT + 1);

  logic [TcW-1:0] tcnt_q, tcnt_d;

  // Counts cycles spent in KSA; held at zero elsewhere so each entry starts fresh.
  always_comb begin
    tcnt_d = '0;
    if (state_q == StKsa) begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign ksa_expired = (tcnt_q == TcW'(KSA_TIMEOUT - 1));
`else
  logic unused_ksa_timeout;
  assign unused_ksa_timeout = (KSA_TIMEOUT == 0);
  assign ksa_expired        = 1'b0;
`endif

  assign key_ok    = (key_len != '0) && (key_len <= (AW + 1)'(KEY_MAX_LEN));
  assign out_free  = !dout_valid_q || dout_ready;
  assign din_ready = (state_q == StCrypt) && out_free && (rem_q != '0);
  assign accept    = din_valid && din_ready;

  always_comb begin
    NS = INIT;
    unique case (state_q)
      StIdle:  NS = INIT;
      StKsa:   NS = KEY_GENE;
      StCrypt: NS = accept ? EN_DE_CODE : HOLD;
      StFlush: NS = HOLD;
      default: NS = INIT;
    endcase
  end

  assign key_init   = (state_q == StKsa) ? ram_rdata : 8'h00;
  assign busy       = (state_q != StIdle);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done       = done_q;
  assign err        = err_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    rem_d        = rem_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (key_ok) begin
            state_d = StKsa;
            idx_d   = '0;
            len_d   = key_len;
            rem_d   = msg_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StKsa: begin
        // Key index cycles 0..key_len-1 for as long as the core keeps scheduling.
        idx_d = ({1'b0, idx_q} == (len_q - 1'b1)) ? '0 : idx_q + 1'b1;
        if (data_rready) begin
          if (rem_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StCrypt;
          end
        end else if (ksa_expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StCrypt: begin
        if (accept) begin
          dout_d       = din ^ num;
          dout_valid_d = 1'b1;
          rem_d        = rem_q - 1'b1;
          if (rem_q == {{(MSG_W - 1){1'b0}}, 1'b1}) begin
            state_d = StFlush;
          end
        end else if (dout_ready) begin
          dout_valid_d = 1'b0;
        end
      end
      StFlush: begin
        if (out_free) begin
          dout_valid_d = 1'b0;
          state_d      = StIdle;
          done_d       = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d      = StIdle;
      dout_valid_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_rc4_seq_ctrl.sv
// tb_rc4_seq_ctrl: directed + randomized bench for rc4_seq_ctrl with a
// byte-queue reference model (dout = din ^ num, in order, no loss).
module tb_rc4_seq_ctrl;
  import rc4_pkg::*;

  localparam int unsigned KML = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_we = 1'b0;
  logic [3:0]  key_addr = '0;
  logic [7:0]  key_wdata = '0;
  logic [4:0]  key_len = '0;
  logic [15:0] msg_len = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        busy, done, err;
  logic [1:0]  NS;
  logic [7:0]  key_init;
  logic        data_rready = 1'b0;
  logic [7:0]  num = '0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] key_mdl [KML];

  rc4_seq_ctrl #(
    .KEY_MAX_LEN (KML),
    .MSG_W       (16),
    .KSA_TIMEOUT (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_we      (key_we),
    .key_addr    (key_addr),
    .key_wdata   (key_wdata),
    .key_len     (key_len),
    .msg_len     (msg_len),
    .start       (start),
    .abort       (abort),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .NS          (NS),
    .key_init    (key_init),
    .data_rready (data_rready),
    .num         (num)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input int a, input logic [7:0] d);
    key_we    = 1'b1;
    key_addr  = 4'(a);
    key_wdata = d;
    tick();
    key_we      = 1'b0;
    key_mdl[a]  = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ns"}, NS, INIT);
    check({tag, "_key_init"}, key_init, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_din_ready"}, din_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Start an operation and watch `ksa` KSA cycles; fire asserts data_rready in the last one.
  task automatic begin_op(input int klen, input int mlen, input int ksa, input bit fire);
    key_len = 5'(klen);
    msg_len = 16'(mlen);
    start   = 1'b1;
    @(negedge clk);
    check("pre_busy", busy, 0);
    tick();
    start = 1'b0;
    for (int i = 0; i < ksa; i++) begin
      if (i == 1) begin
        start   = 1'b1;  // must be ignored while busy
        msg_len = 16'(mlen + 5);
      end
      if (fire && i == ksa - 1) data_rready = 1'b1;
      @(negedge clk);
      check("ksa_key", key_init, key_mdl[i % klen]);
      check("ksa_ns", NS, KEY_GENE);
      check("ksa_busy", busy, 1);
      tick();
      start       = 1'b0;
      data_rready = 1'b0;
    end
  endtask

  // mode 0: AA..DD with num 0F; mode 1: random; mode 2: as mode 0 with a 5-cycle stall.
  task automatic run_msg(input int n, input int mode);
    logic [7:0] q[$];
    logic [7:0] fixed [4];
    logic [7:0] dout_prev;
    logic       stall_prev;
    int acc, dones, cyc, last_pop, done_cyc;
    bit fin;
    fixed      = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    dout_prev  = '0;
    stall_prev = 1'b0;
    acc = 0; dones = 0; cyc = 0; last_pop = -10; done_cyc = -1; fin = 0;
    while (!fin && cyc < 400) begin
      din_valid = (acc < n) && (mode != 1 || $urandom_range(0, 9) < 7);
      din       = (mode == 1) ? 8'($urandom) : fixed[acc % 4];
      num       = (mode == 1) ? 8'($urandom) : 8'h0F;
      if (mode == 1)      dout_ready = ($urandom_range(0, 9) < 6);
      else if (mode == 2) dout_ready = !(cyc >= 3 && cyc < 8);
      else                dout_ready = 1'b1;
      @(negedge clk);
      if (stall_prev) begin
        check("hold_valid", dout_valid, 1);
        check("hold_data", dout, dout_prev);
      end
      if (dout_valid && !dout_ready) begin
        check("stall_din_ready", din_ready, 0);
        check("stall_ns", NS, HOLD);
      end
      if (acc == n) check("ready_after_end", din_ready, 0);
      if (din_valid && din_ready) begin
        q.push_back(din ^ num);
        acc++;
        check("accept_ns", NS, EN_DE_CODE);
      end
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) check("out_unexpected", dout_valid, 0);
        else check("dout", dout, q.pop_front());
        last_pop = cyc;
      end
      if (done === 1'b1) begin
        dones++;
        done_cyc = cyc;
      end
      stall_prev = dout_valid && !dout_ready;
      dout_prev  = dout;
      if (dones > 0 && cyc > done_cyc + 2) fin = 1;
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    check("accepted", acc, n);
    check("drained", q.size(), 0);
    check("done_once", dones, 1);
    check("done_after_last", done_cyc, last_pop + 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int m;
    int klen;
    int k;
    bit seen;

    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    wr_key(0, 8'h01);
    wr_key(1, 8'h02);
    wr_key(2, 8'h03);

    // Key wrap sequence then AA..DD ^ 0F.
    begin_op(3, 4, 7, 1);
    run_msg(4, 0);

    // Output stall mid-message.
    begin_op(3, 8, 3, 1);
    run_msg(8, 2);

    // msg_len == 0: done straight out of KSA.
    begin_op(3, 0, 2, 1);
    @(negedge clk);
    check("zero_len_done", done, 1);
    check("zero_len_busy", busy, 0);
    tick();
    @(negedge clk);
    check("zero_len_done_pulse", done, 0);
    tick();

    // Invalid key lengths.
    key_len = 5'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("klen0_err", err, 1);
    check("klen0_busy", busy, 0);
    tick();
    @(negedge clk);
    check("klen0_err_pulse", err, 0);
    key_len = 5'd17;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("klen17_err", err, 1);
    check("klen17_busy", busy, 0);
    tick();

    // Abort in CRYPT; key write while busy must not land.
    begin_op(3, 6, 4, 1);
    key_we     = 1'b1;
    key_addr   = 4'd0;
    key_wdata  = 8'hFF;
    din_valid  = 1'b1;
    din        = 8'h55;
    num        = 8'h0F;
    dout_ready = 1'b0;
    @(negedge clk);
    tick();
    key_we    = 1'b0;
    din_valid = 1'b0;
    abort     = 1'b1;
    @(negedge clk);
    check("pre_abort_valid", dout_valid, 1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_ns", NS, INIT);
    check("abort_busy", busy, 0);
    check("abort_valid", dout_valid, 0);
    check("abort_done", done, 0);
    tick();
    @(negedge clk);
    check("abort_no_done", done, 0);
    tick();
    begin_op(3, 1, 4, 1);
    run_msg(1, 1);

    // Randomized keys and messages.
    for (int i = 0; i < KML; i++) wr_key(i, 8'($urandom));
    for (int r = 0; r < 3; r++) begin
      klen = $urandom_range(1, KML);
      m    = $urandom_range(1, 12);
      begin_op(klen, m, $urandom_range(klen + 1, 2 * klen + 3), 1);
      run_msg(m, 1);
    end

    // KSA with data_rready held low.
    begin_op(3, 2, 1, 0);
`ifdef RC4_TIMEOUT_EN
    k    = 1;
    seen = 0;
    while (k < 1100 && !seen) begin
      @(negedge clk);
      if (err === 1'b1) seen = 1;
      else begin
        tick();
        k++;
      end
    end
    check("timeout_cycle", k, 1024);
    check("timeout_busy", busy, 0);
    check("timeout_ns", NS, INIT);
    tick();
`else
    k    = 0;
    seen = 0;
    repeat (1100) begin
      @(negedge clk);
      if (err === 1'b1) seen = 1;
      tick();
      k++;
    end
    @(negedge clk);
    check("no_timeout_err", seen, 0);
    check("no_timeout_busy", busy, 1);
    check("no_timeout_ns", NS, KEY_GENE);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    // Asynchronous reset while CRYPT holds an output byte.
    begin_op(3, 5, 2, 1);
    din_valid  = 1'b1;
    din        = 8'h11;
    num        = 8'h22;
    dout_ready = 1'b0;
    @(negedge clk);
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", dout_valid, 1);
    check("pre_rst_dout", dout, 8'h33);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      tick();
    end
    check("rst_no_done", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
